// File: rtl/set_point_scan_pkg.sv
// Shared types and widths for the set-point scan stage: coverage vector size,
// set-operation mode encodings and scan FSM state encodings.
package set_point_scan_pkg;

  localparam int COVERED_SZ = 3;
  localparam int MODE_SZ    = 2;
  localparam int STATE_SZ   = 2;

  typedef enum logic [MODE_SZ-1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } mode_t;

  typedef enum logic [STATE_SZ-1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/set_point_scan_if.sv
// Bus between the run controller and the scan stage: start/configuration in,
// per-point coverage stream out.
interface set_point_scan_if
  import set_point_scan_pkg::*;
#(
  parameter int COORD_W = 4
) ();

  logic                      en;
  logic [6*COORD_W-1:0]      central_i;
  logic [3*COORD_W-1:0]      radius_i;
  logic [MODE_SZ-1:0]        mode_i;
  logic [COVERED_SZ-1:0]     covered_o;
  logic [MODE_SZ-1:0]        mode_buf_o;
  logic [COORD_W-1:0]        pt_x_o;
  logic [COORD_W-1:0]        pt_y_o;
  logic                      pt_valid_o;
  logic                      last_o;
  logic                      busy_o;

  modport master (
    output en, central_i, radius_i, mode_i,
    input  covered_o, mode_buf_o, pt_x_o, pt_y_o, pt_valid_o, last_o, busy_o
  );

  modport slave (
    input  en, central_i, radius_i, mode_i,
    output covered_o, mode_buf_o, pt_x_o, pt_y_o, pt_valid_o, last_o, busy_o
  );

endinterface

// File: rtl/circle_cover.sv
// Two-stage point-in-circle test: stage 1 registers the signed offsets from the
// centre, stage 2 registers whether dx^2+dy^2 <= r^2.
module circle_cover #(
  parameter int COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] r,
  output logic               inside_o
);

  // One extra bit keeps the difference of two unsigned coordinates from wrapping.
  localparam int DW = COORD_W + 1;
  localparam int SW = 2 * COORD_W + 2;

  logic signed [DW-1:0]   dx_reg;
  logic signed [DW-1:0]   dy_reg;
  logic [COORD_W-1:0]     r_reg;
  logic                   valid_reg;
  logic                   inside_reg;

  logic signed [SW-1:0]   dx_ext;
  logic signed [SW-1:0]   dy_ext;
  logic signed [SW-1:0]   dx_sq;
  logic signed [SW-1:0]   dy_sq;
  logic [SW-1:0]          d2;
  logic [2*COORD_W-1:0]   r_wide;
  logic [2*COORD_W-1:0]   r_sq;

  // Stage 1: signed offsets of the point from the centre, radius carried along.
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_reg    <= '0;
      dy_reg    <= '0;
      r_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      dx_reg    <= $signed({1'b0, px}) - $signed({1'b0, cx});
      dy_reg    <= $signed({1'b0, py}) - $signed({1'b0, cy});
      r_reg     <= r;
      valid_reg <= valid_i;
    end
  end

  // Squared distance and squared radius, both at full width so nothing overflows.
  always_comb begin
    dx_ext = {{(SW-DW){dx_reg[DW-1]}}, dx_reg};
    dy_ext = {{(SW-DW){dy_reg[DW-1]}}, dy_reg};
    dx_sq  = dx_ext * dx_ext;
    dy_sq  = dy_ext * dy_ext;
    d2     = $unsigned(dx_sq) + $unsigned(dy_sq);
    r_wide = {{COORD_W{1'b0}}, r_reg};
    r_sq   = r_wide * r_wide;
  end

  // Stage 2: inside-or-on flag, forced low when no point is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      inside_reg <= 1'b0;
    end else begin
      inside_reg <= valid_reg && (d2 <= {2'b00, r_sq});
    end
  end

  assign inside_o = inside_reg;

endmodule

// File: rtl/set_point_scan.sv
// Set-point scan: latches three circles and a mode on start, walks every lattice
// point of the GRID x GRID field and streams a per-point A/B/C coverage vector.
module set_point_scan
  import set_point_scan_pkg::*;
#(
  parameter int GRID    = 8,
  parameter int COORD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  set_point_scan_if.slave  bus
);

  localparam logic [COORD_W-1:0] GRID_C = COORD_W'(GRID);
  localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

  state_t                state_reg;
  state_t                state_next;
  logic                  drain_cnt_reg;

  logic [COORD_W-1:0]    x_reg;
  logic [COORD_W-1:0]    y_reg;

  logic [6*COORD_W-1:0]  central_reg;
  logic [3*COORD_W-1:0]  radius_reg;
  mode_t                 mode_reg;

  logic                  start;
  logic                  issue_valid;
  logic                  issue_last;
  logic                  busy;

  logic                  valid1_reg;
  logic                  last1_reg;
  logic [COORD_W-1:0]    x1_reg;
  logic [COORD_W-1:0]    y1_reg;
  logic                  valid2_reg;
  logic                  last2_reg;
  logic [COORD_W-1:0]    x2_reg;
  logic [COORD_W-1:0]    y2_reg;

  logic [COVERED_SZ-1:0] covered;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: start on en, scan until the corner point, then drain the pipe.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.en) state_next = S_SCAN;
      S_SCAN:  if (x_reg == GRID_C && y_reg == GRID_C) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt_reg) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: start strobe, point issue qualifiers and busy.
  always_comb begin
    start       = (state_reg == S_IDLE) && bus.en;
    issue_valid = (state_reg == S_SCAN);
    issue_last  = (state_reg == S_SCAN) && (x_reg == GRID_C) && (y_reg == GRID_C);
    busy        = (state_reg != S_IDLE);
  end

  // Drain timer: second DRAIN cycle is the one where the last point leaves stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_reg <= 1'b0;
    end else begin
      drain_cnt_reg <= (state_reg == S_DRAIN);
    end
  end

  // Point counters: x is the inner loop, y the outer, both starting at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (start) begin
      x_reg <= ONE_C;
      y_reg <= ONE_C;
    end else if (issue_valid) begin
      if (x_reg == GRID_C) begin
        x_reg <= ONE_C;
        y_reg <= y_reg + ONE_C;
      end else begin
        x_reg <= x_reg + ONE_C;
      end
    end
  end

  // Run configuration, captured only on the accepted start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      central_reg <= '0;
      radius_reg  <= '0;
      mode_reg    <= MODE1;
    end else if (start) begin
      central_reg <= bus.central_i;
      radius_reg  <= bus.radius_i;
      mode_reg    <= mode_t'(bus.mode_i);
    end
  end

  // Coordinate/valid/last side pipeline, aligned with the two circle stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_reg <= 1'b0;
      last1_reg  <= 1'b0;
      x1_reg     <= '0;
      y1_reg     <= '0;
      valid2_reg <= 1'b0;
      last2_reg  <= 1'b0;
      x2_reg     <= '0;
      y2_reg     <= '0;
    end else begin
      valid1_reg <= issue_valid;
      last1_reg  <= issue_last;
      x1_reg     <= issue_valid ? x_reg : '0;
      y1_reg     <= issue_valid ? y_reg : '0;
      valid2_reg <= valid1_reg;
      last2_reg  <= last1_reg;
      x2_reg     <= x1_reg;
      y2_reg     <= y1_reg;
    end
  end

  // One coverage tester per circle; circle A lands in the MSB of the vector.
  for (genvar gi = 0; gi < COVERED_SZ; gi++) begin : g_circle
    circle_cover #(
      .COORD_W (COORD_W)
    ) u_cover (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (issue_valid),
      .px       (x_reg),
      .py       (y_reg),
      .cx       (central_reg[(6-2*gi)*COORD_W-1 -: COORD_W]),
      .cy       (central_reg[(5-2*gi)*COORD_W-1 -: COORD_W]),
      .r        (radius_reg[(3-gi)*COORD_W-1 -: COORD_W]),
      .inside_o (covered[COVERED_SZ-1-gi])
    );
  end

  assign bus.covered_o  = covered;
  assign bus.mode_buf_o = mode_reg;
  assign bus.pt_x_o     = x2_reg;
  assign bus.pt_y_o     = y2_reg;
  assign bus.pt_valid_o = valid2_reg;
  assign bus.last_o     = last2_reg;
  assign bus.busy_o     = busy;

endmodule

// File: tb/tb_set_point_scan.sv
// Directed bench for set_point_scan: whole runs are recorded cycle by cycle,
// then timing is checked and a table of hand-computed points is compared.
`timescale 1ns/1ps
module tb_set_point_scan;
  import set_point_scan_pkg::*;

  localparam int GRID = 8;
  localparam int W    = 4;
  localparam int NS   = 150;
  localparam int NV   = 24;

  typedef struct {
    int         run;
    int         px;
    int         py;
    logic [2:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  set_point_scan_if #(.COORD_W(W)) bus ();

  set_point_scan #(.GRID(GRID), .COORD_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic               s_valid [NS];
  logic               s_last  [NS];
  logic               s_busy  [NS];
  logic [2:0]         s_cov   [NS];
  logic [W-1:0]       s_x     [NS];
  logic [W-1:0]       s_y     [NS];
  logic [MODE_SZ-1:0] s_mode  [NS];

  logic [2:0] maps [4][GRID][GRID];
  vec_t       vecs [NV];

  logic [6*W-1:0] junk_c;
  logic [3*W-1:0] junk_r;

  function automatic logic [6*W-1:0] ctr(int ax, int ay, int bx, int by, int cx, int cy);
    return {W'(ax), W'(ay), W'(bx), W'(by), W'(cx), W'(cy)};
  endfunction

  function automatic logic [3*W-1:0] rad(int ra, int rb, int rc);
    return {W'(ra), W'(rb), W'(rc)};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_junk();
    bus.central_i = junk_c;
    bus.radius_i  = junk_r;
    bus.mode_i    = MODE1;
  endtask

  // Present a configuration with en for one edge; that edge is cycle 0 of the run.
  task automatic start_run(input logic [6*W-1:0] c, input logic [3*W-1:0] r,
                           input logic [MODE_SZ-1:0] m);
    @(negedge clk);
    bus.central_i = c;
    bus.radius_i  = r;
    bus.mode_i    = m;
    bus.en        = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    drive_junk();
  endtask

  // Record cycles 1..ncyc of a run; optionally inject an ignored en, a new start, or a reset.
  task automatic collect(input int ncyc, input int ign_cyc, input int new_cyc,
                         input logic [6*W-1:0] nc, input logic [3*W-1:0] nr,
                         input logic [MODE_SZ-1:0] nm, input int rst_cyc);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      s_valid[n] = bus.pt_valid_o;
      s_last[n]  = bus.last_o;
      s_busy[n]  = bus.busy_o;
      s_cov[n]   = bus.covered_o;
      s_x[n]     = bus.pt_x_o;
      s_y[n]     = bus.pt_y_o;
      s_mode[n]  = bus.mode_buf_o;
      bus.en = (n == ign_cyc) || (n == new_cyc);
      if (n == new_cyc) begin
        bus.central_i = nc;
        bus.radius_i  = nr;
        bus.mode_i    = nm;
      end else begin
        drive_junk();
      end
      rst = (n == rst_cyc);
    end
    bus.en = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(bus.busy_o), 0);
  endtask

  // Timing checks of one run whose start edge is at recorded cycle o, plus map capture.
  task automatic analyze(input int o, input int id, input logic [MODE_SZ-1:0] exp_mode);
    int first, nv, nl, cerr, merr, k, xi, yi;
    first = -1;
    for (int c = o + 1; c <= o + 70; c++)
      if (s_valid[c] && first < 0) first = c;
    chk("first_valid_cycle", first, o + 3);
    nv = 0;
    for (int c = o + 3; c <= o + 66; c++) nv += int'(s_valid[c]);
    chk("valid_contiguous", nv, 64);
    chk("valid_after_last", int'(s_valid[o + 67]), 0);
    nl = 0;
    for (int c = o + 1; c <= o + 67; c++) nl += int'(s_last[c]);
    chk("last_count", nl, 1);
    chk("last_cycle66", int'(s_last[o + 66]), 1);
    chk("busy_cycle1", int'(s_busy[o + 1]), 1);
    chk("busy_cycle66", int'(s_busy[o + 66]), 1);
    chk("busy_cycle67", int'(s_busy[o + 67]), 0);
    cerr = 0;
    for (int c = o + 3; c <= o + 66; c++) begin
      k = c - o - 3;
      if (int'(s_x[c]) != k % GRID + 1 || int'(s_y[c]) != k / GRID + 1) cerr++;
    end
    chk("coord_sequence_errs", cerr, 0);
    merr = 0;
    for (int c = o + 1; c <= o + 67; c++)
      if (s_mode[c] != exp_mode) merr++;
    chk("mode_buf_errs", merr, 0);
    for (int a = 0; a < GRID; a++)
      for (int b = 0; b < GRID; b++) maps[id][a][b] = 3'b101;
    for (int c = o + 3; c <= o + 66; c++) begin
      xi = int'(s_x[c]);
      yi = int'(s_y[c]);
      if (s_valid[c] && xi >= 1 && xi <= GRID && yi >= 1 && yi <= GRID)
        maps[id][xi-1][yi-1] = s_cov[c];
    end
    $display("run %0d analysed: first_valid=%0d valid=%0d last=%0d", id, first, nv, nl);
  endtask

  initial begin
    int cnt_a, cnt_bc, cnt_nz, cnt_all;
    logic [2:0] got;

    // Hand-computed probes: run 0 A=(4,4) r2; run 1 A=(0,0) r3, B=(15,15) r10,
    // C=(8,1) r1; run 2 all at (1,1) r0; run 3 all at (8,8) r15.
    vecs[0]  = '{0, 4, 2, 3'b100};
    vecs[1]  = '{0, 3, 3, 3'b100};
    vecs[2]  = '{0, 6, 4, 3'b100};
    vecs[3]  = '{0, 2, 2, 3'b000};
    vecs[4]  = '{0, 4, 4, 3'b100};
    vecs[5]  = '{0, 4, 6, 3'b100};
    vecs[6]  = '{0, 5, 5, 3'b100};
    vecs[7]  = '{0, 6, 5, 3'b000};
    vecs[8]  = '{0, 1, 1, 3'b000};
    vecs[9]  = '{1, 1, 1, 3'b100};
    vecs[10] = '{1, 2, 2, 3'b100};
    vecs[11] = '{1, 3, 1, 3'b000};
    vecs[12] = '{1, 8, 8, 3'b010};
    vecs[13] = '{1, 8, 1, 3'b001};
    vecs[14] = '{1, 8, 2, 3'b001};
    vecs[15] = '{1, 7, 8, 3'b000};
    vecs[16] = '{2, 1, 1, 3'b111};
    vecs[17] = '{2, 2, 1, 3'b000};
    vecs[18] = '{2, 1, 2, 3'b000};
    vecs[19] = '{2, 8, 8, 3'b000};
    vecs[20] = '{3, 1, 1, 3'b111};
    vecs[21] = '{3, 8, 8, 3'b111};
    vecs[22] = '{3, 1, 8, 3'b111};
    vecs[23] = '{3, 8, 1, 3'b111};

    junk_c = ctr(1, 1, 1, 1, 1, 1);
    junk_r = rad(15, 15, 15);
    bus.en = 1'b0;
    drive_junk();

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(bus.pt_valid_o), 0);
    chk("reset_busy", int'(bus.busy_o), 0);
    chk("reset_covered", int'(bus.covered_o), 0);
    chk("reset_mode_buf", int'(bus.mode_buf_o), 0);
    chk("reset_last", int'(bus.last_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(bus.busy_o), 0);
    chk("idle_coord", int'({bus.pt_x_o, bus.pt_y_o}), 0);

    // Run 0: single circle radius 2; B and C are radius 0 outside the grid.
    start_run(ctr(4, 4, 15, 15, 15, 15), rad(2, 0, 0), MODE2);
    collect(70, 0, 0, junk_c, junk_r, MODE1, 0);
    analyze(0, 0, MODE2);
    wait_idle();

    // Run 1 with ignored en at cycle 20, then a back-to-back run 2 started in cycle 67.
    start_run(ctr(0, 0, 15, 15, 8, 1), rad(3, 10, 1), MODE3);
    collect(140, 20, 67, ctr(1, 1, 1, 1, 1, 1), rad(0, 0, 0), MODE2, 0);
    analyze(0, 1, MODE3);
    chk("b2b_first_valid70", int'(s_valid[70]), 1);
    chk("b2b_no_valid69", int'(s_valid[69]), 0);
    analyze(67, 2, MODE2);
    wait_idle();

    // Reset mid-scan at cycle 30, then a clean full run 3.
    start_run(ctr(8, 8, 8, 8, 8, 8), rad(15, 15, 15), MODE4);
    collect(70, 0, 0, junk_c, junk_r, MODE1, 30);
    chk("pre_rst_valid", int'(s_valid[30]), 1);
    chk("post_rst_valid", int'(s_valid[31]), 0);
    chk("post_rst_busy", int'(s_busy[31]), 0);
    chk("post_rst_covered", int'(s_cov[31]), 0);
    chk("post_rst_mode_buf", int'(s_mode[31]), 0);
    chk("post_rst_coord", int'({s_x[31], s_y[31]}), 0);
    cnt_nz = 0;
    for (int c = 31; c <= 70; c++) cnt_nz += int'(s_valid[c]) + int'(s_last[c]);
    chk("post_rst_quiet", cnt_nz, 0);
    start_run(ctr(8, 8, 8, 8, 8, 8), rad(15, 15, 15), MODE4);
    collect(70, 0, 0, junk_c, junk_r, MODE1, 0);
    analyze(0, 3, MODE4);
    wait_idle();

    // Table-driven point probes.
    for (int i = 0; i < NV; i++) begin
      got = maps[vecs[i].run][vecs[i].px-1][vecs[i].py-1];
      $display("vec %0d run %0d pt (%0d,%0d) covered=%b exp=%b",
               i, vecs[i].run, vecs[i].px, vecs[i].py, got, vecs[i].exp);
      chk($sformatf("vec%0d_covered", i), int'(got), int'(vecs[i].exp));
    end

    // Whole-field counts.
    cnt_a = 0; cnt_bc = 0; cnt_nz = 0; cnt_all = 0;
    for (int a = 0; a < GRID; a++)
      for (int b = 0; b < GRID; b++) begin
        cnt_a   += int'(maps[0][a][b][2]);
        cnt_bc  += int'(maps[0][a][b][1:0] != 2'b00);
        cnt_nz  += int'(maps[2][a][b] != 3'b000);
        cnt_all += int'(maps[3][a][b] == 3'b111);
      end
    chk("run0_a_hits", cnt_a, 13);
    chk("run0_bc_hits", cnt_bc, 0);
    chk("run2_nonzero", cnt_nz, 1);
    chk("run3_all_covered", cnt_all, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
